// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apu_pkg
// Description : Shared constants and types for the APU frame sequencer.
// Revision    : 1.0
// ============================================================================
package apu_pkg;

    localparam int CNT_WIDTH   = 15;
    localparam int STEP1       = 3728;
    localparam int STEP2       = 7456;
    localparam int STEP3       = 11185;
    localparam int STEP4       = 14914;
    localparam int STEP5       = 18640;

    // $4017 bit positions; the port only carries bits [7:6].
    localparam int MODE_BIT    = 7;
    localparam int INHIBIT_BIT = 6;
    localparam int DATA_LSB    = 6;
    localparam int MODE_IDX    = MODE_BIT - DATA_LSB;
    localparam int INHIBIT_IDX = INHIBIT_BIT - DATA_LSB;

    typedef enum logic {
        RUN4 = 1'b0,
        RUN5 = 1'b1
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/apu_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : apu_frame_sequencer_if
// Description : CPU/APU-side signal bundle of the frame sequencer.
// Revision    : 1.0
// ============================================================================
interface apu_frame_sequencer_if;

    logic       iApuCe;
    logic       iWrite;
    logic [1:0] iData;
    logic       iIrqAck;
    logic       oQuarter;
    logic       oHalf;
    logic       oIrq;
    logic       oMode;

    modport master (
        output iApuCe, iWrite, iData, iIrqAck,
        input  oQuarter, oHalf, oIrq, oMode
    );

    modport slave (
        input  iApuCe, iWrite, iData, iIrqAck,
        output oQuarter, oHalf, oIrq, oMode
    );

endinterface
`default_nettype wire

// File: rtl/apu_frame_step_decode.sv
`default_nettype none
// ============================================================================
// Module      : apu_frame_step_decode
// Description : Combinational step-table decode of the frame counter.
// Revision    : 1.0
// ============================================================================
module apu_frame_step_decode #(
    parameter int CNT_WIDTH = apu_pkg::CNT_WIDTH,
    parameter int STEP1     = apu_pkg::STEP1,
    parameter int STEP2     = apu_pkg::STEP2,
    parameter int STEP3     = apu_pkg::STEP3,
    parameter int STEP4     = apu_pkg::STEP4,
    parameter int STEP5     = apu_pkg::STEP5
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  apu_pkg::mode_e       mode_i,
    output logic                 quarter_o,
    output logic                 half_o,
    output logic                 irq_set_o,
    output logic                 wrap_o
);

    always_comb begin
        quarter_o = 1'b0;
        half_o    = 1'b0;
        irq_set_o = 1'b0;
        wrap_o    = 1'b0;
        if (cnt_i == CNT_WIDTH'(STEP1) || cnt_i == CNT_WIDTH'(STEP3)) begin
            quarter_o = 1'b1;
        end
        if (cnt_i == CNT_WIDTH'(STEP2)) begin
            quarter_o = 1'b1;
            half_o    = 1'b1;
        end
        // STEP4 is silent in 5-step mode; only the 4-step sequence ends there.
        if (cnt_i == CNT_WIDTH'(STEP4) && mode_i == apu_pkg::RUN4) begin
            quarter_o = 1'b1;
            half_o    = 1'b1;
            irq_set_o = 1'b1;
            wrap_o    = 1'b1;
        end
        if (cnt_i == CNT_WIDTH'(STEP5) && mode_i == apu_pkg::RUN5) begin
            quarter_o = 1'b1;
            half_o    = 1'b1;
            wrap_o    = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : apu_frame_sequencer
// Description : NES APU frame counter: quarter/half-frame strobes and IRQ.
// Revision    : 1.0
// ============================================================================
module apu_frame_sequencer #(
    parameter int CNT_WIDTH = apu_pkg::CNT_WIDTH,
    parameter int STEP1     = apu_pkg::STEP1,
    parameter int STEP2     = apu_pkg::STEP2,
    parameter int STEP3     = apu_pkg::STEP3,
    parameter int STEP4     = apu_pkg::STEP4,
    parameter int STEP5     = apu_pkg::STEP5
) (
    input  logic                        iClk,
    input  logic                        iReset,
    apu_frame_sequencer_if.slave        bus
);

    import apu_pkg::mode_e;
    import apu_pkg::RUN4;
    import apu_pkg::RUN5;
    import apu_pkg::MODE_IDX;
    import apu_pkg::INHIBIT_IDX;

    logic [CNT_WIDTH-1:0] cnt_q;
    mode_e                mode_q;
    logic                 inhibit_q;
    logic                 irq_q;
    logic                 pend_q;
    logic                 pend5_q;
    logic                 quarter_q;
    logic                 half_q;

    mode_e                mode_d;
    logic                 inhibit_d;
    logic                 restart_d;
    logic                 irq_set_d;
    logic                 irq_clr_wr_d;
    logic                 dec_quarter;
    logic                 dec_half;
    logic                 dec_irq_set;
    logic                 dec_wrap;

    // A write takes effect on its own edge, so decode and wrap see the new mode.
    assign mode_d       = bus.iWrite ? mode_e'(bus.iData[MODE_IDX]) : mode_q;
    assign inhibit_d    = bus.iWrite ? bus.iData[INHIBIT_IDX] : inhibit_q;
    assign restart_d    = bus.iApuCe && pend_q && !bus.iWrite;
    assign irq_clr_wr_d = bus.iWrite && bus.iData[INHIBIT_IDX];
    assign irq_set_d    = bus.iApuCe && !restart_d && dec_irq_set && !inhibit_d;

    apu_frame_step_decode #(
        .CNT_WIDTH (CNT_WIDTH),
        .STEP1     (STEP1),
        .STEP2     (STEP2),
        .STEP3     (STEP3),
        .STEP4     (STEP4),
        .STEP5     (STEP5)
    ) u_decode (
        .cnt_i     (cnt_q),
        .mode_i    (mode_d),
        .quarter_o (dec_quarter),
        .half_o    (dec_half),
        .irq_set_o (dec_irq_set),
        .wrap_o    (dec_wrap)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            cnt_q     <= '0;
            mode_q    <= RUN4;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            pend_q    <= 1'b0;
            pend5_q   <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            if (bus.iWrite) begin
                pend_q  <= 1'b1;
                pend5_q <= bus.iData[MODE_IDX];
            end
            if (bus.iApuCe) begin
                if (restart_d) begin
                    cnt_q     <= '0;
                    pend_q    <= 1'b0;
                    quarter_q <= pend5_q;
                    half_q    <= pend5_q;
                end else begin
                    quarter_q <= dec_quarter;
                    half_q    <= dec_half;
                    cnt_q     <= dec_wrap ? '0 : cnt_q + 1'b1;
                end
            end
            // Inhibit-write clear beats a set, which beats an acknowledge.
            if (irq_clr_wr_d) begin
                irq_q <= 1'b0;
            end else if (irq_set_d) begin
                irq_q <= 1'b1;
            end else if (bus.iIrqAck) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign bus.oQuarter = quarter_q;
    assign bus.oHalf    = half_q;
    assign bus.oIrq     = irq_q;
    assign bus.oMode    = (mode_q == RUN5);

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apu_frame_sequencer
// Description : Scoreboard bench for the frame sequencer, scaled step table.
// Revision    : 1.0
// ============================================================================
module tb_apu_frame_sequencer;

    localparam int TS1 = 10;
    localparam int TS2 = 20;
    localparam int TS3 = 31;
    localparam int TS4 = 41;
    localparam int TS5 = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apu_frame_sequencer_if bus();

    apu_frame_sequencer #(
        .CNT_WIDTH (6),
        .STEP1     (TS1),
        .STEP2     (TS2),
        .STEP3     (TS3),
        .STEP4     (TS4),
        .STEP5     (TS5)
    ) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    typedef struct {
        int   at;
        logic q;
        logic h;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  ce_idx = 0;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One two-clock slot; an APU cycle enable here is sampled on the first edge.
    task automatic cyc(input bit ce, input bit wr, input logic [1:0] d, input bit ack);
        @(posedge clk);
        #1;
        bus.iApuCe  = ce;
        bus.iWrite  = wr;
        bus.iData   = d;
        bus.iIrqAck = ack;
        if (ce) ce_idx++;
        @(posedge clk);
        #1;
        bus.iApuCe  = 1'b0;
        bus.iWrite  = 1'b0;
        bus.iIrqAck = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic expect_ev(input int at, input bit q, input bit h);
        exp_q.push_back('{at, q, h});
    endtask

    // The k-th APU cycle after a counter restart decodes cnt = k-1.
    task automatic seq_partial(input int base);
        expect_ev(base + TS1 + 1, 1'b1, 1'b0);
        expect_ev(base + TS2 + 1, 1'b1, 1'b1);
        expect_ev(base + TS3 + 1, 1'b1, 1'b0);
    endtask

    task automatic seq4(input int base);
        seq_partial(base);
        expect_ev(base + TS4 + 1, 1'b1, 1'b1);
    endtask

    task automatic seq5(input int base);
        seq_partial(base);
        expect_ev(base + TS5 + 1, 1'b1, 1'b1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_quarter", int'(bus.oQuarter), 0);
        chk("rst_half",    int'(bus.oHalf),    0);
        chk("rst_irq",     int'(bus.oIrq),     0);
        chk("rst_mode",    int'(bus.oMode),    0);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.oQuarter || bus.oHalf)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected q=%0b h=%0b at apu cycle %0d",
                         bus.oQuarter, bus.oHalf, ce_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.at != ce_idx || mon_e.q !== bus.oQuarter || mon_e.h !== bus.oHalf) begin
                    errors++;
                    $display("FAIL strobe: got cycle %0d q=%0b h=%0b expected cycle %0d q=%0b h=%0b",
                             ce_idx, bus.oQuarter, bus.oHalf, mon_e.at, mon_e.q, mon_e.h);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.iApuCe  = 1'b0;
        bus.iWrite  = 1'b0;
        bus.iData   = 2'b00;
        bus.iIrqAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs();

        // Two full 4-step periods, IRQ rise, acknowledge, and set-beats-ack.
        seq4(ce_idx);
        seq4(ce_idx + TS4 + 1);
        run(TS4);
        chk("irq_before_step4", int'(bus.oIrq), 0);
        run(1);
        chk("irq_at_step4", int'(bus.oIrq), 1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        chk("irq_ack", int'(bus.oIrq), 0);
        run(TS4);
        chk("irq_low_mid", int'(bus.oIrq), 0);
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        chk("irq_set_beats_ack", int'(bus.oIrq), 1);

        // Switch to 5-step: immediate quarter+half on restart, two periods.
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        chk("irq_ack2", int'(bus.oIrq), 0);
        cyc(1'b0, 1'b1, 2'b10, 1'b0);
        chk("mode_run5", int'(bus.oMode), 1);
        expect_ev(ce_idx + 1, 1'b1, 1'b1);
        run(1);
        seq5(ce_idx);
        seq5(ce_idx + TS5 + 1);
        run(TS4 + 1);
        chk("no_irq_run5", int'(bus.oIrq), 0);
        run(TS5 - TS4);
        run(TS5 + 1);

        // Back to 4-step (silent restart), then inhibit clears a raised IRQ.
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        chk("mode_run4", int'(bus.oMode), 0);
        run(1);
        seq4(ce_idx);
        run(TS4 + 1);
        chk("irq_run4", int'(bus.oIrq), 1);
        cyc(1'b0, 1'b1, 2'b01, 1'b0);
        chk("irq_inhibit_clear", int'(bus.oIrq), 0);
        run(1);
        seq4(ce_idx);
        run(TS4 + 1);
        chk("irq_inhibited", int'(bus.oIrq), 0);

        // Write on the same edge as STEP4: decodes with new 5-step mode, restart deferred.
        seq_partial(ce_idx);
        run(TS4);
        cyc(1'b1, 1'b1, 2'b10, 1'b0);
        chk("same_edge_mode", int'(bus.oMode), 1);
        chk("same_edge_irq", int'(bus.oIrq), 0);
        expect_ev(ce_idx + 1, 1'b1, 1'b1);
        run(1);

        // Two writes before an APU cycle: latest wins, single silent restart.
        cyc(1'b0, 1'b1, 2'b10, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        chk("double_write_mode", int'(bus.oMode), 0);
        run(1);
        seq4(ce_idx);
        run(TS4 + 1);
        chk("irq_after_double_write", int'(bus.oIrq), 1);

        // Inhibit write on the STEP4 edge: strobes still fire, IRQ stays clear.
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        chk("irq_ack3", int'(bus.oIrq), 0);
        seq_partial(ce_idx);
        run(TS4);
        expect_ev(ce_idx + 1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2'b01, 1'b0);
        chk("inhibit_beats_set", int'(bus.oIrq), 0);
        run(1);

        // Reset mid-sequence with a 5-step restart pending.
        expect_ev(ce_idx + TS1 + 1, 1'b1, 1'b0);
        run(TS2);
        cyc(1'b0, 1'b1, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs();
        expect_ev(ce_idx + TS1 + 1, 1'b1, 1'b0);
        run(TS1 + 1);
        repeat (2) @(posedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame-counter scheduler for the NES APU. Counts APU cycles and issues one-clock quarter-frame and half-frame strobes that sequence the envelope, linear-counter, length-counter and sweep units. Runs in 4-step or 5-step mode, configured by CPU writes to $4017. Raises the frame IRQ.

## Interface
Parameters:
- CNT_WIDTH, 15: width of the APU-cycle counter; must hold STEP5.
- STEP1, 3728: count for step 1 (quarter).
- STEP2, 7456: count for step 2 (quarter + half).
- STEP3, 11185: count for step 3 (quarter).
- STEP4, 14914: last count in 4-step mode (quarter + half + IRQ); silent in 5-step mode.
- STEP5, 18640: last count in 5-step mode (quarter + half).

Ports:
- iClk, in, 1: system clock. The design has one clock.
- iReset, in, 1: reset, synchronous and active-high.
- iApuCe, in, 1: APU-cycle enable, one iClk wide.
- iWrite, in, 1: $4017 write strobe, one iClk wide.
- iData, in, 2: write data bits [7:6]; bit 1 = mode (1 = 5-step), bit 0 = IRQ inhibit.
- iIrqAck, in, 1: $4015 read strobe; clears the frame IRQ.
- oQuarter, out, 1: quarter-frame strobe, one iClk wide.
- oHalf, out, 1: half-frame strobe, one iClk wide.
- oIrq, out, 1: frame IRQ flag, level.
- oMode, out, 1: current mode.

## Operation
- Registers:
  - cnt[CNT_WIDTH-1:0]
  - mode
  - inhibit
  - irq
  - pend: counter-restart pending
  - pend5: the pending restart requests 5-step mode
- FSM has two states, RUN4 and RUN5, held in mode.
  - RUN4 goes to RUN5 on a write with iData[1]=1.
  - RUN5 goes to RUN4 on a write with iData[1]=0.
- Each iApuCe edge with no restart applied:
  - Decode cnt against the step table.
  - Then wrap cnt to 0 if cnt equals the last step of the current mode (STEP4 in RUN4, STEP5 in RUN5); otherwise cnt = cnt + 1.
- Step decode, on an iApuCe edge:
  - cnt == STEP1 or STEP3: pulse oQuarter.
  - cnt == STEP2: pulse oQuarter and oHalf.
  - cnt == STEP4 in RUN4: pulse oQuarter and oHalf; set irq if inhibit = 0.
  - cnt == STEP4 in RUN5: no strobe.
  - cnt == STEP5 in RUN5: pulse oQuarter and oHalf.
- Write handling, on an iWrite edge:
  - mode and inhibit update immediately.
  - Set pend = 1 and pend5 = iData[1].
  - If iData[0] = 1, clear irq.
- Restart, on the first iApuCe edge strictly after the write edge, with pend = 1:
  - Set cnt = 0 and clear pend.
  - If pend5 = 1, pulse oQuarter and oHalf.
  - The normal step decode is suppressed on this edge.
- oIrq = irq.
- IRQ clear: iIrqAck clears irq.
- Counter arithmetic is unsigned. cnt never exceeds STEP5. Writes cannot produce an out-of-range cnt.

## Timing
- Reset values, all registered:
  - cnt = 0, mode = 0, inhibit = 0, irq = 0, pend = 0, pend5 = 0.
  - oQuarter = 0, oHalf = 0, oIrq = 0, oMode = 0.
- Latency:
  - Strobes and oIrq assert on the iClk edge that samples iApuCe, and are visible in the following cycle.
  - Strobes are deasserted one cycle later.
- Sequence period:
  - RUN4: STEP4+1 = 14915 APU cycles.
  - RUN5: STEP5+1 = 18641 APU cycles.
- Simultaneous events:
  - iWrite and iApuCe on the same edge: the restart is deferred to the next iApuCe; the current iApuCe decodes normally with the new mode.
  - A second write while pend = 1: the latest data wins; a single restart follows.
  - IRQ set and iIrqAck on the same edge: set wins.
  - IRQ set and an inhibit write on the same edge: the clear wins.
- iReset mid-sequence: returns all registers to reset values on that edge, including any pending restart. No strobe follows until cnt next reaches STEP1.
- Mode change without a restart edge: the wrap rule uses the new mode immediately. A RUN5 to RUN4 switch with cnt > STEP4 cannot occur, because a restart is always pending.

## Structure
- Shared package apu_pkg holds:
  - the default step constants STEP1..STEP5;
  - CNT_WIDTH;
  - the $4017 bit positions MODE_BIT = 7 and INHIBIT_BIT = 6.
- One natural sub-module, apu_frame_step_decode: purely combinational. It takes cnt and mode and returns quarter, half, irq_set and wrap.

## Test plan
- Reset, then iApuCe every 2 clocks:
  - oQuarter pulses at cnt 3728, 7456, 11185 and 14914.
  - oHalf pulses at 7456 and 14914.
  - oIrq rises after 14914; the period is 14915.
- Write iData = 2'b10:
  - On the next iApuCe, oQuarter and oHalf pulse together; cnt = 0.
  - No strobe or IRQ at 14914.
  - Strobes pulse at 18640; the period is 18641.
- IRQ clear:
  - With oIrq = 1, pulse iIrqAck: oIrq falls next cycle.
  - Repeat, but write iData = 2'b01: oIrq falls; it stays 0 through the next STEP4.
- Drive iWrite and iApuCe on the same edge:
  - The restart occurs on the next iApuCe.
  - Two writes (2'b10 then 2'b00) before an iApuCe: one restart, no strobe, mode = 0.
- Simultaneous IRQ set and iIrqAck at cnt 14914: oIrq = 1.
- Assert iReset at cnt = 9000: all outputs 0; the next oQuarter comes 3729 APU cycles later.
